riscv_lsu: RTL and testbench

// - RV32I load/store unit. Sits downstream of the ALU, which supplies the effective address, and upstream of register writeback.
// - Accepts one LOAD_S/STORE_S op at a time and drives a req/gnt/rvalid data-memory bus.
// - Generates byte enables and lane-replicated store data. Sign/zero-extends load data and returns it with the destination rd.

---
 rtl/riscv_lsu_if.sv | 55 +++++
 rtl/riscv_lsu.sv | 178 +++++++++++++++++
 tb/tb_riscv_lsu.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_lsu_if.sv
// rtl/riscv_lsu_if.sv - execute-side request/response and data-memory bus interfaces of the load/store unit
interface riscv_lsu_req_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_store;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic [4:0]            req_rd;
    logic                  resp_valid;
    logic [31:0]           resp_data;
    logic [4:0]            resp_rd;
    logic                  resp_we;
    logic                  resp_err;
    logic                  busy;

    // execute stage: offers ops, consumes responses
    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd,
        input  req_ready, resp_valid, resp_data, resp_rd, resp_we, resp_err, busy
    );

    // load/store unit: accepts ops, produces responses
    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd,
        output req_ready, resp_valid, resp_data, resp_rd, resp_we, resp_err, busy
    );
endinterface

interface riscv_lsu_mem_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [3:0]            mem_be;
    logic [31:0]           mem_wdata;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [31:0]           mem_rdata;

    // load/store unit side of the data-memory bus
    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    // memory side of the data-memory bus
    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/riscv_lsu.sv
// rtl/riscv_lsu.sv - RV32I load/store unit; RISCV_LSU_MISALIGN_TRAP_EN makes misaligned H/W accesses error out
module riscv_lsu #(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    riscv_lsu_req_if.slave  req_if,
    riscv_lsu_mem_if.master mem_if
);
    localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_store;
    logic [2:0]            r_funct3;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [4:0]            r_rd;
    logic                  r_err;
    logic [31:0]           r_data;
    logic [CW-1:0]         r_cnt;

    logic                  w_accept;
    logic                  w_timeout;
    logic                  w_expire;
    logic                  w_misalign;
    logic                  w_dec_err;
    logic [1:0]            w_off;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata;
    logic [31:0]           w_tmp;
    logic [31:0]           w_ext;

    // decode the offered op: unsupported funct3 (and misalignment when trapping) never touches memory
    always_comb begin
        w_misalign = 1'b0;
        w_dec_err  = 1'b1;
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
        case (req_if.req_funct3[1:0])
            2'b01:   w_misalign = req_if.req_addr[0];
            2'b10:   w_misalign = |req_if.req_addr[1:0];
            default: w_misalign = 1'b0;
        endcase
`endif
        case (req_if.req_funct3)
            3'b000, 3'b001, 3'b010: w_dec_err = w_misalign;
            3'b100, 3'b101:         w_dec_err = req_if.req_store;
            default:                w_dec_err = 1'b1;
        endcase
    end

    // lane selection: offsets below the access size are ignored, so H/W always hit their natural lanes
    always_comb begin
        w_off   = 2'b00;
        w_be    = 4'b1111;
        w_wdata = r_wdata;
        case (r_funct3[1:0])
            2'b00: begin
                w_off   = r_addr[1:0];
                w_be    = 4'b0001 << r_addr[1:0];
                w_wdata = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_off   = {r_addr[1], 1'b0};
                w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{r_wdata[15:0]}};
            end
            default: ;
        endcase
        w_tmp = mem_if.mem_rdata >> {w_off, 3'b000};
        w_ext = w_tmp;
        case (r_funct3)
            3'b000:  w_ext = {{24{w_tmp[7]}}, w_tmp[7:0]};
            3'b001:  w_ext = {{16{w_tmp[15]}}, w_tmp[15:0]};
            3'b100:  w_ext = {24'd0, w_tmp[7:0]};
            3'b101:  w_ext = {16'd0, w_tmp[15:0]};
            default: w_ext = w_tmp;
        endcase
    end

    // the last counted cycle of REQ/WAIT; a gnt/rvalid arriving in that same cycle still wins
    assign w_expire = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1));

    // next-state logic
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_if.req_valid) begin
                    w_accept = 1'b1;
                    w_next   = w_dec_err ? S_RESP : S_REQ;
                end
            end
            S_REQ: begin
                if (mem_if.mem_gnt) begin
                    w_next = r_store ? S_RESP : S_WAIT;
                end else if (w_expire) begin
                    w_timeout = 1'b1;
                    w_next    = S_RESP;
                end
            end
            S_WAIT: begin
                if (mem_if.mem_rvalid) begin
                    w_next = S_RESP;
                end else if (w_expire) begin
                    w_timeout = 1'b1;
                    w_next    = S_RESP;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // op capture, load data capture, error flag and timeout counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_store  <= 1'b0;
            r_funct3 <= 3'b000;
            r_addr   <= '0;
            r_wdata  <= 32'd0;
            r_rd     <= 5'd0;
            r_err    <= 1'b0;
            r_data   <= 32'd0;
            r_cnt    <= '0;
        end else begin
            if (w_accept) begin
                r_store  <= req_if.req_store;
                r_funct3 <= req_if.req_funct3;
                r_addr   <= req_if.req_addr;
                r_wdata  <= req_if.req_wdata;
                r_rd     <= req_if.req_rd;
                r_err    <= w_dec_err;
                r_data   <= 32'd0;
            end
            if (w_timeout) begin
                r_err  <= 1'b1;
                r_data <= 32'd0;
            end
            if (r_state == S_WAIT && mem_if.mem_rvalid) begin
                r_data <= w_ext;
            end
            if (w_accept || (r_state == S_REQ && mem_if.mem_gnt)) begin
                r_cnt <= '0;
            end else if (r_state == S_REQ || r_state == S_WAIT) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign req_if.req_ready  = (r_state == S_IDLE);
    assign req_if.busy       = (r_state != S_IDLE);
    assign req_if.resp_valid = (r_state == S_RESP);
    assign req_if.resp_data  = r_data;
    assign req_if.resp_rd    = r_rd;
    assign req_if.resp_we    = (r_state == S_RESP) && !r_store && !r_err && (r_rd != 5'd0);
    assign req_if.resp_err   = (r_state == S_RESP) && r_err;

    assign mem_if.mem_req    = (r_state == S_REQ);
    assign mem_if.mem_we     = r_store;
    assign mem_if.mem_addr   = {r_addr[ADDR_WIDTH-1:2], 2'b00};
    assign mem_if.mem_be     = w_be;
    assign mem_if.mem_wdata  = w_wdata;
endmodule

// File: tb/tb_riscv_lsu.sv
// tb/tb_riscv_lsu.sv - directed self-checking bench for riscv_lsu (TIMEOUT=4)
module tb_riscv_lsu;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    riscv_lsu_req_if #(.ADDR_WIDTH(32)) rif ();
    riscv_lsu_mem_if #(.ADDR_WIDTH(32)) mif ();

    riscv_lsu #(.ADDR_WIDTH(32), .TIMEOUT(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_if (rif),
        .mem_if (mif)
    );

    localparam logic [2:0]  LD_F3   [6] = '{3'b010, 3'b000, 3'b100, 3'b101, 3'b001, 3'b000};
    localparam logic [31:0] LD_ADDR [6] = '{32'h100, 32'h103, 32'h103, 32'h102, 32'h100, 32'h101};
    localparam logic [31:0] LD_RDAT [6] = '{32'hDEADBEEF, 32'h80123456, 32'h80123456, 32'h80123456, 32'h1234F00D, 32'h00007F00};
    localparam logic [4:0]  LD_RD   [6] = '{5'd5, 5'd1, 5'd2, 5'd3, 5'd0, 5'd4};
    localparam logic [3:0]  LD_BE   [6] = '{4'b1111, 4'b1000, 4'b1000, 4'b1100, 4'b0011, 4'b0010};
    localparam logic [31:0] LD_EXP  [6] = '{32'hDEADBEEF, 32'hFFFFFF80, 32'h00000080, 32'h00008012, 32'hFFFFF00D, 32'h0000007F};

    localparam logic [2:0]  ST_F3   [3] = '{3'b001, 3'b000, 3'b010};
    localparam logic [31:0] ST_ADDR [3] = '{32'h202, 32'h201, 32'h204};
    localparam logic [31:0] ST_WD   [3] = '{32'h1234ABCD, 32'h000000EF, 32'h01020304};
    localparam logic [31:0] ST_MADR [3] = '{32'h200, 32'h200, 32'h204};
    localparam logic [3:0]  ST_BE   [3] = '{4'b1100, 4'b0010, 4'b1111};
    localparam logic [31:0] ST_MWD  [3] = '{32'hABCDABCD, 32'hEFEFEFEF, 32'h01020304};

    localparam logic        BAD_ST  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    localparam logic [2:0]  BAD_F3  [4] = '{3'b011, 3'b110, 3'b100, 3'b101};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // offer one op while the unit is idle; returns in the first cycle after acceptance
    task automatic offer(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd);
        rif.req_store  = st;
        rif.req_funct3 = f3;
        rif.req_addr   = a;
        rif.req_wdata  = wd;
        rif.req_rd     = rd;
        rif.req_valid  = 1'b1;
        tick();
        rif.req_valid  = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (mif.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mif.mem_req); end
        checks++; if (rif.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", rif.resp_valid); end
        checks++; if (rif.resp_we !== 1'b0) begin errors++; $display("FAIL reset_resp_we: got %b want 0", rif.resp_we); end
        checks++; if (rif.resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err: got %b want 0", rif.resp_err); end
        checks++; if (rif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", rif.busy); end
        checks++; if (rif.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", rif.req_ready); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_loads();
        for (int i = 0; i < 6; i++) begin
            offer(1'b0, LD_F3[i], LD_ADDR[i], 32'h0, LD_RD[i]);
            checks++; if (mif.mem_req !== 1'b1 || mif.mem_we !== 1'b0) begin errors++; $display("FAIL load%0d_req: got req=%b we=%b want req=1 we=0", i, mif.mem_req, mif.mem_we); end
            checks++; if (mif.mem_addr !== (LD_ADDR[i] & 32'hFFFFFFFC)) begin errors++; $display("FAIL load%0d_addr: got %h want %h", i, mif.mem_addr, LD_ADDR[i] & 32'hFFFFFFFC); end
            checks++; if (mif.mem_be !== LD_BE[i]) begin errors++; $display("FAIL load%0d_be: got %b want %b", i, mif.mem_be, LD_BE[i]); end
            mif.mem_gnt = 1'b1;
            tick();
            mif.mem_gnt = 1'b0;
            checks++; if (rif.resp_valid !== 1'b0 || mif.mem_req !== 1'b0) begin errors++; $display("FAIL load%0d_wait: got resp_valid=%b mem_req=%b want 0 0", i, rif.resp_valid, mif.mem_req); end
            mif.mem_rvalid = 1'b1;
            mif.mem_rdata  = LD_RDAT[i];
            tick();
            mif.mem_rvalid = 1'b0;
            checks++; if (rif.resp_valid !== 1'b1) begin errors++; $display("FAIL load%0d_resp_valid: got %b want 1", i, rif.resp_valid); end
            checks++; if (rif.resp_data !== LD_EXP[i]) begin errors++; $display("FAIL load%0d_data: got %h want %h", i, rif.resp_data, LD_EXP[i]); end
            checks++; if (rif.resp_rd !== LD_RD[i]) begin errors++; $display("FAIL load%0d_rd: got %0d want %0d", i, rif.resp_rd, LD_RD[i]); end
            checks++; if (rif.resp_we !== (LD_RD[i] != 5'd0)) begin errors++; $display("FAIL load%0d_we: got %b want %b", i, rif.resp_we, LD_RD[i] != 5'd0); end
            checks++; if (rif.resp_err !== 1'b0) begin errors++; $display("FAIL load%0d_err: got %b want 0", i, rif.resp_err); end
            tick();
            checks++; if (rif.resp_valid !== 1'b0 || rif.req_ready !== 1'b1) begin errors++; $display("FAIL load%0d_idle: got resp_valid=%b ready=%b want 0 1", i, rif.resp_valid, rif.req_ready); end
        end
    endtask

    task automatic test_back_to_back_stores();
        for (int i = 0; i < 3; i++) begin
            offer(1'b1, ST_F3[i], ST_ADDR[i], ST_WD[i], 5'd9);
            checks++; if (mif.mem_req !== 1'b1 || mif.mem_we !== 1'b1) begin errors++; $display("FAIL store%0d_req: got req=%b we=%b want 1 1", i, mif.mem_req, mif.mem_we); end
            checks++; if (mif.mem_addr !== ST_MADR[i]) begin errors++; $display("FAIL store%0d_addr: got %h want %h", i, mif.mem_addr, ST_MADR[i]); end
            checks++; if (mif.mem_be !== ST_BE[i]) begin errors++; $display("FAIL store%0d_be: got %b want %b", i, mif.mem_be, ST_BE[i]); end
            checks++; if (mif.mem_wdata !== ST_MWD[i]) begin errors++; $display("FAIL store%0d_wdata: got %h want %h", i, mif.mem_wdata, ST_MWD[i]); end
            mif.mem_gnt = 1'b1;
            tick();
            mif.mem_gnt = 1'b0;
            checks++; if (rif.resp_valid !== 1'b1) begin errors++; $display("FAIL store%0d_resp_valid: got %b want 1", i, rif.resp_valid); end
            checks++; if (rif.resp_we !== 1'b0 || rif.resp_err !== 1'b0) begin errors++; $display("FAIL store%0d_we_err: got we=%b err=%b want 0 0", i, rif.resp_we, rif.resp_err); end
            checks++; if (rif.resp_data !== 32'h0) begin errors++; $display("FAIL store%0d_data: got %h want 0", i, rif.resp_data); end
            tick();
        end
    endtask

    task automatic test_gnt_stall();
        offer(1'b0, 3'b010, 32'h300, 32'h0, 5'd9);
        rif.req_valid  = 1'b1;
        rif.req_funct3 = 3'b000;
        rif.req_addr   = 32'h700;
        for (int i = 0; i < 4; i++) begin
            checks++; if (mif.mem_req !== 1'b1) begin errors++; $display("FAIL stall%0d_req: got %b want 1", i, mif.mem_req); end
            checks++; if (mif.mem_addr !== 32'h300 || mif.mem_be !== 4'b1111) begin errors++; $display("FAIL stall%0d_addr_be: got %h/%b want 00000300/1111", i, mif.mem_addr, mif.mem_be); end
            checks++; if (rif.req_ready !== 1'b0 || rif.busy !== 1'b1) begin errors++; $display("FAIL stall%0d_ready_busy: got %b/%b want 0/1", i, rif.req_ready, rif.busy); end
            if (i == 3) mif.mem_gnt = 1'b1;
            tick();
        end
        mif.mem_gnt    = 1'b0;
        checks++; if (mif.mem_req !== 1'b0 || rif.busy !== 1'b1) begin errors++; $display("FAIL stall_wait: got req=%b busy=%b want 0 1", mif.mem_req, rif.busy); end
        mif.mem_rvalid = 1'b1;
        mif.mem_rdata  = 32'h11223344;
        tick();
        mif.mem_rvalid = 1'b0;
        rif.req_valid  = 1'b0;
        checks++; if (rif.resp_valid !== 1'b1 || rif.resp_err !== 1'b0) begin errors++; $display("FAIL stall_resp: got valid=%b err=%b want 1 0", rif.resp_valid, rif.resp_err); end
        checks++; if (rif.resp_data !== 32'h11223344 || rif.resp_rd !== 5'd9) begin errors++; $display("FAIL stall_data: got %h rd %0d want 11223344 rd 9", rif.resp_data, rif.resp_rd); end
        tick();
        checks++; if (rif.busy !== 1'b0 || mif.mem_req !== 1'b0) begin errors++; $display("FAIL stall_no_extra_accept: got busy=%b req=%b want 0 0", rif.busy, mif.mem_req); end
    endtask

    task automatic test_timeout();
        int n;
        offer(1'b0, 3'b010, 32'h400, 32'h0, 5'd6);
        n = 0;
        for (int i = 0; i < 12 && mif.mem_req === 1'b1; i++) begin
            n++;
            tick();
        end
        checks++; if (n != 4) begin errors++; $display("FAIL to_req_cycles: got %0d want 4", n); end
        checks++; if (rif.resp_valid !== 1'b1 || rif.resp_err !== 1'b1) begin errors++; $display("FAIL to_req_resp: got valid=%b err=%b want 1 1", rif.resp_valid, rif.resp_err); end
        checks++; if (rif.resp_data !== 32'h0 || rif.resp_we !== 1'b0) begin errors++; $display("FAIL to_req_data_we: got %h we=%b want 0 0", rif.resp_data, rif.resp_we); end
        tick();
        offer(1'b0, 3'b010, 32'h404, 32'h0, 5'd6);
        mif.mem_gnt = 1'b1;
        tick();
        mif.mem_gnt = 1'b0;
        n = 0;
        for (int i = 0; i < 12 && rif.resp_valid !== 1'b1; i++) begin
            n++;
            tick();
        end
        checks++; if (n != 4) begin errors++; $display("FAIL to_wait_cycles: got %0d want 4", n); end
        checks++; if (rif.resp_valid !== 1'b1 || rif.resp_err !== 1'b1 || rif.resp_data !== 32'h0) begin errors++; $display("FAIL to_wait_resp: got valid=%b err=%b data=%h want 1 1 0", rif.resp_valid, rif.resp_err, rif.resp_data); end
        tick();
        mif.mem_rvalid = 1'b1;
        mif.mem_rdata  = 32'h55555555;
        tick();
        mif.mem_rvalid = 1'b0;
        checks++; if (rif.resp_valid !== 1'b0 || rif.busy !== 1'b0) begin errors++; $display("FAIL to_late_rvalid: got valid=%b busy=%b want 0 0", rif.resp_valid, rif.busy); end
    endtask

    task automatic test_reset_in_wait();
        int seen;
        offer(1'b0, 3'b010, 32'h600, 32'h0, 5'd8);
        mif.mem_gnt = 1'b1;
        tick();
        mif.mem_gnt = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (mif.mem_req !== 1'b0 || rif.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_wait_outputs: got req=%b valid=%b want 0 0", mif.mem_req, rif.resp_valid); end
        checks++; if (rif.req_ready !== 1'b1 || rif.busy !== 1'b0) begin errors++; $display("FAIL rst_wait_ready: got ready=%b busy=%b want 1 0", rif.req_ready, rif.busy); end
        #2;
        rst_n = 1'b1;
        mif.mem_rvalid = 1'b1;
        mif.mem_rdata  = 32'h99999999;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            mif.mem_rvalid = 1'b0;
            if (rif.resp_valid === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rst_wait_no_resp: got %0d responses want 0", seen); end
    endtask

    task automatic test_invalid();
        for (int i = 0; i < 4; i++) begin
            offer(BAD_ST[i], BAD_F3[i], 32'h800, 32'hFFFFFFFF, 5'd3);
            checks++; if (mif.mem_req !== 1'b0) begin errors++; $display("FAIL bad%0d_mem_req: got %b want 0", i, mif.mem_req); end
            checks++; if (rif.resp_valid !== 1'b1 || rif.resp_err !== 1'b1) begin errors++; $display("FAIL bad%0d_resp: got valid=%b err=%b want 1 1", i, rif.resp_valid, rif.resp_err); end
            checks++; if (rif.resp_we !== 1'b0 || rif.resp_data !== 32'h0) begin errors++; $display("FAIL bad%0d_we_data: got we=%b data=%h want 0 0", i, rif.resp_we, rif.resp_data); end
            tick();
        end
    endtask

    task automatic test_misalign();
        offer(1'b0, 3'b010, 32'h101, 32'h0, 5'd7);
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
        checks++; if (mif.mem_req !== 1'b0) begin errors++; $display("FAIL mis_mem_req: got %b want 0", mif.mem_req); end
        checks++; if (rif.resp_valid !== 1'b1 || rif.resp_err !== 1'b1 || rif.resp_we !== 1'b0) begin errors++; $display("FAIL mis_resp: got valid=%b err=%b we=%b want 1 1 0", rif.resp_valid, rif.resp_err, rif.resp_we); end
        tick();
`else
        checks++; if (mif.mem_req !== 1'b1 || mif.mem_addr !== 32'h100 || mif.mem_be !== 4'b1111) begin errors++; $display("FAIL mis_req: got req=%b addr=%h be=%b want 1 00000100 1111", mif.mem_req, mif.mem_addr, mif.mem_be); end
        mif.mem_gnt = 1'b1;
        tick();
        mif.mem_gnt    = 1'b0;
        mif.mem_rvalid = 1'b1;
        mif.mem_rdata  = 32'hCAFEF00D;
        tick();
        mif.mem_rvalid = 1'b0;
        checks++; if (rif.resp_valid !== 1'b1 || rif.resp_err !== 1'b0 || rif.resp_we !== 1'b1) begin errors++; $display("FAIL mis_resp: got valid=%b err=%b we=%b want 1 0 1", rif.resp_valid, rif.resp_err, rif.resp_we); end
        checks++; if (rif.resp_data !== 32'hCAFEF00D) begin errors++; $display("FAIL mis_data: got %h want cafef00d", rif.resp_data); end
        tick();
`endif
    endtask

    initial begin
        rif.req_valid  = 1'b0;
        rif.req_store  = 1'b0;
        rif.req_funct3 = 3'b000;
        rif.req_addr   = 32'h0;
        rif.req_wdata  = 32'h0;
        rif.req_rd     = 5'd0;
        mif.mem_gnt    = 1'b0;
        mif.mem_rvalid = 1'b0;
        mif.mem_rdata  = 32'h0;
        test_reset();
        test_loads();
        test_back_to_back_stores();
        test_gnt_stall();
        test_timeout();
        test_reset_in_wait();
        test_invalid();
        test_misalign();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
